// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed display scan path.
package display_pkg;

  localparam int   DEFAULT_DIGITS = 4;
  localparam int   NIBBLE_W       = 4;
  localparam logic ANODE_ON       = 1'b0;

  // Width of a digit index; never narrower than one bit.
  function automatic int idx_width(input int digits);
    return (digits <= 2) ? 1 : $clog2(digits);
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running divider: counts 0..REFRESH_DIV-1 and raises tick at terminal count.
module refresh_prescaler #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (REFRESH_DIV <= 2) ? 1 : $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scan_driver.sv
// Scans a double-buffered DIGITS-nibble value across an active-low digit enable bus.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int DIGITS      = DEFAULT_DIGITS,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [NIBBLE_W*DIGITS-1:0]   data_in,
  output logic [NIBBLE_W-1:0]          digit_value,
  output logic [DIGITS-1:0]            digit_sel,
  output logic                         blank,
  output logic                         frame_done,
  output logic                         pending
);

  localparam int IW = idx_width(DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  logic                        tick;
  logic                        wrap;
  logic [IW-1:0]               idx_q, idx_d;
  logic [NIBBLE_W*DIGITS-1:0]  disp_q, disp_d;
  logic [NIBBLE_W*DIGITS-1:0]  pend_val_q, pend_val_d;
  logic                        pend_q, pend_d;
  logic [DIGITS-1:0]           sel_q, sel_d;
  logic [NIBBLE_W-1:0]         val_q, val_d;
  logic                        frame_q, frame_d;

  refresh_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Outputs are computed from the post-edge index and display so they land with the step.
  always_comb begin
    wrap       = tick && (idx_q == LAST_IDX);
    idx_d      = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end
    pend_val_d = load ? data_in : pend_val_q;
    pend_d     = pend_q;
    disp_d     = disp_q;
    if (wrap) begin
      pend_d = 1'b0;
      if (load) begin
        disp_d = data_in;
      end else if (pend_q) begin
        disp_d = pend_val_q;
      end
    end else if (load) begin
      pend_d = 1'b1;
    end
    frame_d = wrap;
    val_d   = '0;
    sel_d   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      sel_d[k] = (idx_d == IW'(k)) ? ANODE_ON : ~ANODE_ON;
      if (idx_d == IW'(k)) begin
        val_d = disp_d[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      disp_q     <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      sel_q      <= {{(DIGITS-1){~ANODE_ON}}, ANODE_ON};
      val_q      <= '0;
      frame_q    <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      sel_q      <= sel_d;
      val_q      <= val_d;
      frame_q    <= frame_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msnz_d;
  logic          blank_q, blank_d;

  // Digit 0 is the floor, so an all-zero value still shows a single "0".
  always_comb begin
    msnz_d = '0;
    for (int k = 1; k < DIGITS; k++) begin
      if (disp_d[k*NIBBLE_W +: NIBBLE_W] != '0) begin
        msnz_d = IW'(k);
      end
    end
    blank_d = (idx_d > msnz_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

  assign digit_value = val_q;
  assign digit_sel   = sel_q;
  assign frame_done  = frame_q;
  assign pending     = pend_q;

endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Time-multiplexes a DIGITS-wide hex value onto a common-segment multi-digit display.
- Sits directly upstream of the seven-segment decoder. Each digit period it presents one 4-bit nibble on digit_value, which feeds the decoder's value input, and drives the matching active-low digit enable.
- New values are double-buffered and committed only at frame boundaries, so a digit never tears mid-scan.

Parameters:
- DIGITS, 4, number of display digits (2..8).
- REFRESH_DIV, 50000, clock cycles each digit stays enabled (>=2).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  one-cycle strobe; capture data_in as the pending value.
- data_in  input  4*DIGITS  hex value; nibble k (bits 4k+3:4k) goes to digit k, with digit 0 least significant.
- digit_value  output  4  nibble for the currently enabled digit; connects to the decoder's value input.
- digit_sel  output  DIGITS  active-low one-hot digit enable.
- blank  output  1  high = downstream forces all segments off for the current digit.
- frame_done  output  1  one-cycle pulse on the cycle the scan wraps to digit 0.
- pending  output  1  high while a loaded value awaits commit.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. It is sampled only on the rising edge of clk and overrides all other inputs.
- Reset values:
  - prescaler = 0, digit index = 0.
  - display register = 0, pending register = 0, pending = 0.
  - digit_sel = all ones except bit 0 low.
  - digit_value = 0, blank = 0, frame_done = 0.
- Prescaler: counts 0..REFRESH_DIV-1. Terminal count raises an internal tick and wraps to 0.
- Digit index: on tick, advances by 1. At DIGITS-1 it wraps to 0. Order is 0,1,...,DIGITS-1,0.
- Outputs are registered and update on the same edge as the index:
  - digit_sel = ~(1 << next index).
  - digit_value = nibble[next index] of the display register as it is after this edge's commit.
- Frame boundary: the tick on which the index wraps DIGITS-1 -> 0.
  - frame_done is high for exactly the one cycle following that edge.
  - On that edge, if pending or load is high, the display register takes the new value, pending clears, and the new value is shown immediately on digit 0.
- load: captures data_in into the pending register and sets pending on the next edge.
  - Load while pending: last write wins; no error.
  - Load on the frame-boundary edge: data_in is committed directly and pending stays 0.
- Latency: load to visible on digit 0 is at most DIGITS*REFRESH_DIV cycles.
- Reset mid-scan: returns to digit 0 and prescaler 0 on the next edge; any pending value is discarded.
- No combinational path from any input to any output.

Optional Feature:
- LEADING_ZERO_BLANK_EN
  - Defined: blank is high for every digit index above the most-significant nonzero nibble of the display register. Digit 0 is never blanked, so value 0 shows "0". blank is registered and aligned with digit_value.
  - Undefined: blank is constant 0; no blanking logic is synthesised.

Decomposition:
- Shared package (display_pkg):
  - default DIGITS
  - a function returning the index width (clog2 of DIGITS, minimum 1)
  - constant ANODE_ON = 1'b0
  - nibble width constant 4, also used by the decoder
- One sub-module: refresh_prescaler (parameter REFRESH_DIV; ports clk, rst, tick). It is a free-running counter with a one-cycle tick at terminal count.

Test Plan:
- Reset with REFRESH_DIV=4, DIGITS=4 -> digit_sel=4'b1110, digit_value=0. Sel steps 1110->1101->1011->0111->1110 every 4 cycles. frame_done pulses once per 16 cycles.
- Load 16'h1234 at digit 1 -> pending=1, display unchanged. At wrap: digit 0 shows 4 and pending=0. Subsequent digits show 3, 2, 1.
- Load 16'hAAAA, then 16'h5B5B two cycles later, same frame -> only 5B5B is committed; AAAA is never displayed.
- Load 16'hBEEF on the exact frame-boundary cycle -> digit 0 shows F on the next cycle and pending stays 0.
- Assert rst while digit 2 is active with a value pending -> next cycle digit_sel=1110 and pending=0. The display register is 0 and the old pending value never appears.
- With LEADING_ZERO_BLANK_EN: value 16'h0042 -> blank=1 on digits 3 and 2, 0 on digits 1 and 0. Value 16'h0000 -> blank=1 on digits 3..1, 0 on digit 0.
